// File: rtl/mem_wb_reg_if.sv
// mem_wb_reg_if: bundle of the MEM-stage result going into the MEM/WB
// pipeline register and the registered WB-stage values coming out of it.
//
//   mem_valid/mem_wd/mem_wreg/mem_wdata/mem_whilo/mem_hi/mem_lo
//       MEM-stage instruction result (bubble when mem_valid = 0)
//   wb_valid/wb_wd/wb_wreg/wb_wdata/wb_whilo/wb_hi/wb_lo
//       registered copy presented to the register file and HI/LO unit
//
// Modports:
//   master - the pipeline side that produces mem_* and consumes wb_*
//   slave  - the MEM/WB register itself
interface mem_wb_reg_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              mem_valid;
  logic [ADDR_W-1:0] mem_wd;
  logic              mem_wreg;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_whilo;
  logic [DATA_W-1:0] mem_hi;
  logic [DATA_W-1:0] mem_lo;

  logic              wb_valid;
  logic [ADDR_W-1:0] wb_wd;
  logic              wb_wreg;
  logic [DATA_W-1:0] wb_wdata;
  logic              wb_whilo;
  logic [DATA_W-1:0] wb_hi;
  logic [DATA_W-1:0] wb_lo;

  modport master (
    output mem_valid, mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
    input  wb_valid, wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo
  );

  modport slave (
    input  mem_valid, mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
    output wb_valid, wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo
  );
endinterface

// File: rtl/mem_wb_reg.sv
// mem_wb_reg: MEM -> WB pipeline register of the 5-stage CPU.
//
// Ports:
//   clk        system clock, all state changes on the rising edge
//   resetn     synchronous reset, active high (1 = reset)
//   stall      stall vector; bit4 = MEM stalled, bit5 = WB stalled
//   flush      pipeline flush; writes a bubble into WB
//   bus        mem_wb_reg_if.slave: mem_* inputs, registered wb_* outputs
//   retire_cnt modulo-2^CNT_W count of instructions that entered WB
//
// Per edge, in priority order: reset, flush (bubble), stall[5] (hold),
// stall[4] (bubble), otherwise load. An invalid MEM instruction loads as a
// bubble so that write enables are never asserted for it.
module mem_wb_reg #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [5:0]       stall,
  input  logic             flush,
  mem_wb_reg_if.slave      bus,
  output logic [CNT_W-1:0] retire_cnt
);

  logic              wb_valid_reg;
  logic [ADDR_W-1:0] wb_wd_reg;
  logic              wb_wreg_reg;
  logic [DATA_W-1:0] wb_wdata_reg;
  logic              wb_whilo_reg;
  logic [DATA_W-1:0] wb_hi_reg;
  logic [DATA_W-1:0] wb_lo_reg;
  logic [CNT_W-1:0]  retire_cnt_reg;

  // Only the MEM and WB stall bits matter here; earlier-stage bits are ignored.
  logic unused_stall;
  assign unused_stall = ^stall[3:0];

  // A bubble is written whenever this edge clears the stage: flush always,
  // otherwise only when WB itself is not held.
  logic bubble_next;
  logic load_next;
  assign bubble_next = flush | (~stall[5] & (stall[4] | ~bus.mem_valid));
  assign load_next   = ~flush & ~stall[5] & ~stall[4] & bus.mem_valid;

  always_ff @(posedge clk) begin
    if (resetn) begin
      wb_valid_reg   <= 1'b0;
      wb_wd_reg      <= '0;
      wb_wreg_reg    <= 1'b0;
      wb_wdata_reg   <= '0;
      wb_whilo_reg   <= 1'b0;
      wb_hi_reg      <= '0;
      wb_lo_reg      <= '0;
      retire_cnt_reg <= '0;
    end else if (bubble_next) begin
      wb_valid_reg   <= 1'b0;
      wb_wd_reg      <= '0;
      wb_wreg_reg    <= 1'b0;
      wb_wdata_reg   <= '0;
      wb_whilo_reg   <= 1'b0;
      wb_hi_reg      <= '0;
      wb_lo_reg      <= '0;
    end else if (load_next) begin
      wb_valid_reg   <= 1'b1;
      wb_wd_reg      <= bus.mem_wd;
      wb_wreg_reg    <= bus.mem_wreg;
      wb_wdata_reg   <= bus.mem_wdata;
      wb_whilo_reg   <= bus.mem_whilo;
      wb_hi_reg      <= bus.mem_hi;
      wb_lo_reg      <= bus.mem_lo;
      // Natural overflow of the CNT_W-bit add gives the required wrap.
      retire_cnt_reg <= retire_cnt_reg + 1'b1;
    end
    // Remaining case is stall[5] without flush: every register holds.
  end

  assign bus.wb_valid = wb_valid_reg;
  assign bus.wb_wd    = wb_wd_reg;
  assign bus.wb_wreg  = wb_wreg_reg;
  assign bus.wb_wdata = wb_wdata_reg;
  assign bus.wb_whilo = wb_whilo_reg;
  assign bus.wb_hi    = wb_hi_reg;
  assign bus.wb_lo    = wb_lo_reg;
  assign retire_cnt   = retire_cnt_reg;

endmodule

// File: tb/tb_mem_wb_reg.sv
// tb_mem_wb_reg: directed and randomized checks of mem_wb_reg against a
// behavioural model. Two instances share the stimulus: one with the default
// 32-bit counter and one with a 4-bit counter to reach the wrap quickly.
module tb_mem_wb_reg;

  logic        clk = 1'b0;
  logic        resetn;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] cnt_a;
  logic [3:0]  cnt_b;

  always #5 clk = ~clk;

  mem_wb_reg_if #(.DATA_W(32), .ADDR_W(5)) bus_a ();
  mem_wb_reg_if #(.DATA_W(32), .ADDR_W(5)) bus_b ();

  mem_wb_reg #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .stall      (stall),
    .flush      (flush),
    .bus        (bus_a.slave),
    .retire_cnt (cnt_a)
  );

  mem_wb_reg #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut4 (
    .clk        (clk),
    .resetn     (resetn),
    .stall      (stall),
    .flush      (flush),
    .bus        (bus_b.slave),
    .retire_cnt (cnt_b)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;

  // Behavioural model of what WB should hold.
  bit          m_valid;
  int          m_wd;
  bit          m_wreg;
  logic [31:0] m_wdata;
  bit          m_whilo;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  longint      m_count;   // unbounded count of retirements since reset

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  task automatic drive(input bit v, input int wd, input bit wreg, input logic [31:0] wdata,
                       input bit whilo, input logic [31:0] hi, input logic [31:0] lo);
    bus_a.mem_valid = v;     bus_b.mem_valid = v;
    bus_a.mem_wd    = 5'(wd); bus_b.mem_wd   = 5'(wd);
    bus_a.mem_wreg  = wreg;  bus_b.mem_wreg  = wreg;
    bus_a.mem_wdata = wdata; bus_b.mem_wdata = wdata;
    bus_a.mem_whilo = whilo; bus_b.mem_whilo = whilo;
    bus_a.mem_hi    = hi;    bus_b.mem_hi    = hi;
    bus_a.mem_lo    = lo;    bus_b.mem_lo    = lo;
  endtask

  task automatic model_clear();
    m_valid = 0; m_wd = 0; m_wreg = 0; m_wdata = 0; m_whilo = 0; m_hi = 0; m_lo = 0;
  endtask

  // One clock edge: evaluate the spec's priority rules on the applied inputs,
  // then compare both instances one time unit after the edge.
  task automatic tick();
    @(posedge clk);
    cycle++;
    if (resetn) begin
      model_clear();
      m_count = 0;
    end else if (flush) begin
      model_clear();
    end else if (stall[5]) begin
      // hold
    end else if (stall[4] || !bus_a.mem_valid) begin
      model_clear();
    end else begin
      m_valid = 1;
      m_wd    = int'(bus_a.mem_wd);
      m_wreg  = bus_a.mem_wreg;
      m_wdata = bus_a.mem_wdata;
      m_whilo = bus_a.mem_whilo;
      m_hi    = bus_a.mem_hi;
      m_lo    = bus_a.mem_lo;
      m_count++;
    end
    #1;
    $display("cycle %0d rst=%b flush=%b stall=%b v=%b -> wb_valid=%b wd=%0d wdata=%h cnt=%0d cnt4=%0d",
             cycle, resetn, flush, stall, bus_a.mem_valid, bus_a.wb_valid, bus_a.wb_wd,
             bus_a.wb_wdata, cnt_a, cnt_b);
    check("wb_valid", 64'(bus_a.wb_valid), 64'(m_valid));
    check("wb_wd",    64'(bus_a.wb_wd),    64'(m_wd));
    check("wb_wreg",  64'(bus_a.wb_wreg),  64'(m_wreg));
    check("wb_wdata", 64'(bus_a.wb_wdata), 64'(m_wdata));
    check("wb_whilo", 64'(bus_a.wb_whilo), 64'(m_whilo));
    check("wb_hi",    64'(bus_a.wb_hi),    64'(m_hi));
    check("wb_lo",    64'(bus_a.wb_lo),    64'(m_lo));
    check("retire_cnt",   64'(cnt_a), 64'(m_count % 64'h1_0000_0000));
    check("retire_cnt4",  64'(cnt_b), 64'(m_count % 16));
    check("b_wb_wdata",   64'(bus_b.wb_wdata), 64'(m_wdata));
    check("b_wb_valid",   64'(bus_b.wb_valid), 64'(m_valid));
  endtask

  initial begin
    model_clear();
    m_count = 0;
    flush   = 0;
    stall   = '0;

    // Reset with busy inputs for two cycles.
    resetn = 1;
    drive(1, 17, 1, 32'h5555_AAAA, 1, 32'h1111_2222, 32'h3333_4444);
    tick();
    tick();
    check("rst_valid", 64'(bus_a.wb_valid), 64'd0);
    check("rst_cnt",   64'(cnt_a), 64'd0);

    // First load after reset release.
    resetn = 0;
    drive(1, 3, 1, 32'hDEADBEEF, 0, 0, 0);
    tick();
    check("load_wd",    64'(bus_a.wb_wd), 64'd3);
    check("load_wdata", 64'(bus_a.wb_wdata), 64'hDEADBEEF);
    check("load_cnt",   64'(cnt_a), 64'd1);

    // Stall hold.
    drive(1, 7, 1, 32'h12345678, 0, 0, 0);
    tick();
    stall = 6'b111111;
    for (int i = 0; i < 3; i++) begin
      drive(1, 8, 1, $urandom, 0, 0, 0);
      tick();
      check("hold_wdata", 64'(bus_a.wb_wdata), 64'h12345678);
      check("hold_cnt",   64'(cnt_a), 64'd2);
    end
    stall = '0;
    drive(1, 8, 1, 32'hCAFEF00D, 0, 0, 0);
    tick();
    check("release_wdata", 64'(bus_a.wb_wdata), 64'hCAFEF00D);

    // Bubble insert from MEM stall.
    stall = 6'b011111;
    drive(1, 9, 1, 32'h0BAD_0BAD, 0, 0, 0);
    tick();
    check("bub_wreg", 64'(bus_a.wb_wreg), 64'd0);
    check("bub_cnt",  64'(cnt_a), 64'd3);

    // Flush beats a full stall.
    stall = '0;
    drive(1, 10, 1, 32'h7777_0000, 0, 0, 0);
    tick();
    flush = 1;
    stall = 6'b111111;
    tick();
    check("flush_valid", 64'(bus_a.wb_valid), 64'd0);
    check("flush_cnt",   64'(cnt_a), 64'd4);
    flush = 0;
    stall = '0;

    // HI/LO path, then a bubble clears the HI/LO enable.
    drive(1, 0, 0, 0, 1, 32'hAAAA0000, 32'h0000BBBB);
    tick();
    check("hilo_whilo", 64'(bus_a.wb_whilo), 64'd1);
    check("hilo_hi",    64'(bus_a.wb_hi), 64'hAAAA0000);
    check("hilo_lo",    64'(bus_a.wb_lo), 64'h0000BBBB);
    drive(0, 4, 1, 32'h1, 1, 32'h2, 32'h3);
    tick();
    check("hilo_bubble", 64'(bus_a.wb_whilo), 64'd0);

    // Counter wrap on the 4-bit instance, with a flush in the middle.
    resetn = 1;
    tick();
    resetn = 0;
    for (int i = 0; i < 17; i++) begin
      if (i == 8) begin
        flush = 1;
        tick();
        check("wrap_flush_hold", 64'(cnt_b), 64'd8);
        flush = 0;
      end
      drive(1, i, 1, 32'(i), 0, 0, 0);
      tick();
      check("wrap_seq", 64'(cnt_b), 64'((i + 1) % 16));
    end

    // Randomized traffic, including rare resets and non-monotonic stalls.
    for (int i = 0; i < 300; i++) begin
      resetn = ($urandom_range(0, 49) == 0);
      flush  = ($urandom_range(0, 11) == 0);
      case ($urandom_range(0, 9))
        0:       stall = 6'b111111;
        1:       stall = 6'b011111;
        2:       stall = 6'b100000;
        default: stall = '0;
      endcase
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom_range(0, 1),
            $urandom, $urandom_range(0, 1), $urandom, $urandom);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
